// File: rtl/banked_ram_dp.sv
// banked_ram_dp: dual-port buffer split into 2^TAG_W single-write/single-read banks.
// Port A has priority over port B whenever both target the same bank on the same channel.
module banked_ram_dp #(
    parameter int TAG_W      = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s_write_addr_a,
    input  logic                  s_write_req_a,
    input  logic [DATA_WIDTH-1:0] s_write_data_a,
    input  logic [ADDR_WIDTH-1:0] s_read_addr_a,
    input  logic                  s_read_req_a,
    output logic [DATA_WIDTH-1:0] s_read_data_a,
    input  logic [ADDR_WIDTH-1:0] s_write_addr_b,
    input  logic                  s_write_req_b,
    input  logic [DATA_WIDTH-1:0] s_write_data_b,
    input  logic [ADDR_WIDTH-1:0] s_read_addr_b,
    input  logic                  s_read_req_b,
    output logic [DATA_WIDTH-1:0] s_read_data_b
);
    localparam int BANK_ADDR_W = ADDR_WIDTH - TAG_W;
    localparam int NUM_BANKS   = 1 << TAG_W;
    localparam int BANK_DEPTH  = 1 << BANK_ADDR_W;

    logic [TAG_W-1:0]       wbank_a, wbank_b, rbank_a, rbank_b;
    logic [BANK_ADDR_W-1:0] wloc_a, wloc_b, rloc_a, rloc_b;
    logic                   rd_grant_b;
    logic [DATA_WIDTH-1:0]  bank_rd_a [NUM_BANKS];
    logic [DATA_WIDTH-1:0]  bank_rd_b [NUM_BANKS];
    logic [DATA_WIDTH-1:0]  rd_data_a_q, rd_data_b_q;

    assign wbank_a = s_write_addr_a[ADDR_WIDTH-1 -: TAG_W];
    assign wbank_b = s_write_addr_b[ADDR_WIDTH-1 -: TAG_W];
    assign rbank_a = s_read_addr_a[ADDR_WIDTH-1 -: TAG_W];
    assign rbank_b = s_read_addr_b[ADDR_WIDTH-1 -: TAG_W];
    assign wloc_a  = s_write_addr_a[BANK_ADDR_W-1:0];
    assign wloc_b  = s_write_addr_b[BANK_ADDR_W-1:0];
    assign rloc_a  = s_read_addr_a[BANK_ADDR_W-1:0];
    assign rloc_b  = s_read_addr_b[BANK_ADDR_W-1:0];
    assign rd_grant_b = s_read_req_b && !(s_read_req_a && rbank_a == rbank_b);

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem_q [BANK_DEPTH];
        logic                  we_a, we_b;
        assign we_a = s_write_req_a && wbank_a == TAG_W'(g);
        assign we_b = s_write_req_b && wbank_b == TAG_W'(g) && !we_a;
        // Contents survive reset; reset only blocks writes.
        always_ff @(posedge clk or posedge reset) begin
            if (!reset) begin
                if (we_a) mem_q[wloc_a] <= s_write_data_a;
                else if (we_b) mem_q[wloc_b] <= s_write_data_b;
            end
        end
        assign bank_rd_a[g] = mem_q[rloc_a];
        assign bank_rd_b[g] = mem_q[rloc_b];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
        end else begin
            if (s_read_req_a) rd_data_a_q <= bank_rd_a[rbank_a];
            if (rd_grant_b) rd_data_b_q <= bank_rd_b[rbank_b];
        end
    end

    assign s_read_data_a = rd_data_a_q;
    assign s_read_data_b = rd_data_b_q;
endmodule

// File: tb/tb_banked_ram_dp.sv
// tb_banked_ram_dp: directed vectors checked against a flat-memory reference model.
module tb_banked_ram_dp;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  wa_addr, ra_addr, wb_addr, rb_addr;
    logic        wa_req, ra_req, wb_req, rb_req;
    logic [31:0] wa_data, wb_data;
    logic [31:0] rd_a, rd_b;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    banked_ram_dp dut (
        .clk(clk), .reset(reset),
        .s_write_addr_a(wa_addr), .s_write_req_a(wa_req), .s_write_data_a(wa_data),
        .s_read_addr_a(ra_addr), .s_read_req_a(ra_req), .s_read_data_a(rd_a),
        .s_write_addr_b(wb_addr), .s_write_req_b(wb_req), .s_write_data_b(wb_data),
        .s_read_addr_b(rb_addr), .s_read_req_b(rb_req), .s_read_data_b(rd_b)
    );

    // Reference: one flat 1024-word memory, bank = addr / 256.
    logic [31:0] m [1024];
    bit          v [1024];
    logic [31:0] exp_a, exp_b;
    bit          known_a = 0, known_b = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_a = 0; exp_b = 0; known_a = 1; known_b = 1;
        end else begin
            if (ra_req) begin exp_a = m[ra_addr]; known_a = v[ra_addr]; end
            if (rb_req && !(ra_req && ra_addr / 256 == rb_addr / 256)) begin
                exp_b = m[rb_addr]; known_b = v[rb_addr];
            end
            if (wa_req) begin m[wa_addr] = wa_data; v[wa_addr] = 1; end
            if (wb_req && !(wa_req && wa_addr / 256 == wb_addr / 256)) begin
                m[wb_addr] = wb_data; v[wb_addr] = 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (known_a) check("model_a", rd_a, exp_a);
        if (known_b) check("model_b", rd_b, exp_b);
    end

    task automatic idle();
        wa_req = 0; ra_req = 0; wb_req = 0; rb_req = 0;
        wa_addr = 0; ra_addr = 0; wb_addr = 0; rb_addr = 0;
        wa_data = 0; wb_data = 0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1;
        idle();
        tick(); tick();
        check("reset_a", rd_a, 32'h0);
        check("reset_b", rd_b, 32'h0);
        reset = 0;
        wa_req = 1; wa_addr = 10'h005; wa_data = 32'hDEADBEEF; tick();
        idle(); ra_req = 1; ra_addr = 10'h005; tick();
        check("basic_a", rd_a, 32'hDEADBEEF);
        idle(); tick(); tick();
        check("hold_a", rd_a, 32'hDEADBEEF);
        wa_req = 1; wa_addr = 10'h3FF; wa_data = 32'h11111111; tick();
        idle(); rb_req = 1; rb_addr = 10'h3FF; tick();
        check("cross_b", rd_b, 32'h11111111);
        idle(); wb_req = 1; wb_addr = 10'h010; wb_data = 32'h22222222;
        ra_req = 1; ra_addr = 10'h3FF; tick();
        check("cross_a", rd_a, 32'h11111111);
        idle(); ra_req = 1; ra_addr = 10'h010; tick();
        check("b_write_landed", rd_a, 32'h22222222);
        idle(); ra_req = 1; ra_addr = 10'h005; rb_req = 1; rb_addr = 10'h3FF; tick();
        check("par_a", rd_a, 32'hDEADBEEF);
        check("par_b", rd_b, 32'h11111111);
        idle(); wb_req = 1; wb_addr = 10'h101; wb_data = 32'h0BAD0101; tick();
        idle(); wa_req = 1; wa_addr = 10'h100; wa_data = 32'hAAAA0000;
        wb_req = 1; wb_addr = 10'h101; wb_data = 32'hBBBB0000; tick();
        idle(); ra_req = 1; ra_addr = 10'h100; tick();
        check("wconf_a_wins", rd_a, 32'hAAAA0000);
        idle(); ra_req = 1; ra_addr = 10'h101; tick();
        check("wconf_b_dropped", rd_a, 32'h0BAD0101);
        idle(); ra_req = 1; ra_addr = 10'h100; rb_req = 1; rb_addr = 10'h101; tick();
        check("rconf_a", rd_a, 32'hAAAA0000);
        check("rconf_b_held", rd_b, 32'h11111111);
        idle(); wa_req = 1; wa_addr = 10'h200; wa_data = 32'h1; tick();
        idle(); wa_req = 1; wa_addr = 10'h200; wa_data = 32'h2;
        rb_req = 1; rb_addr = 10'h200; tick();
        check("rdw_old", rd_b, 32'h1);
        idle(); rb_req = 1; rb_addr = 10'h200; tick();
        check("rdw_new", rd_b, 32'h2);
        idle();
        @(posedge clk); #2;
        reset = 1; #1;
        check("async_rst_a", rd_a, 32'h0);
        check("async_rst_b", rd_b, 32'h0);
        wa_req = 1; wa_addr = 10'h005; wa_data = 32'hFFFFFFFF;
        wb_req = 1; wb_addr = 10'h200; wb_data = 32'hFFFFFFFF;
        tick(); tick();
        check("in_rst_a", rd_a, 32'h0);
        idle(); reset = 0;
        ra_req = 1; ra_addr = 10'h005; rb_req = 1; rb_addr = 10'h200; tick();
        check("kept_a", rd_a, 32'hDEADBEEF);
        check("kept_b", rd_b, 32'h2);
        idle(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/banked_ram_dp.md
Name: banked_ram_dp

Overview:
- Dual-port on-chip buffer built from 2^TAG_W independent single-write/single-read banks.
- The top TAG_W address bits select the bank.
- Port A serves the memory/DMA side; port B serves the compute-array side. Each port has its own read and write channel.
- Supports double buffering: while one side fills a bank, the other side drains a different bank, so both run at full rate.

Parameters:
- TAG_W, 2, log2 of the bank count (NUM_BANKS = 2^TAG_W); must satisfy 1 <= TAG_W < ADDR_WIDTH.
- ADDR_WIDTH, 10, word address width; total depth is 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, word width in bits.
- Derived: BANK_ADDR_W = ADDR_WIDTH-TAG_W; BANK_DEPTH = 2^BANK_ADDR_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_write_addr_a  in  ADDR_WIDTH  port A write address.
- s_write_req_a  in  1  port A write enable.
- s_write_data_a  in  DATA_WIDTH  port A write data.
- s_read_addr_a  in  ADDR_WIDTH  port A read address.
- s_read_req_a  in  1  port A read enable.
- s_read_data_a  out  DATA_WIDTH  port A read data, registered.
- s_write_addr_b  in  ADDR_WIDTH  port B write address.
- s_write_req_b  in  1  port B write enable.
- s_write_data_b  in  DATA_WIDTH  port B write data.
- s_read_addr_b  in  ADDR_WIDTH  port B read address.
- s_read_req_b  in  1  port B read enable.
- s_read_data_b  out  DATA_WIDTH  port B read data, registered.

Behaviour:
- Address split: bank = addr[ADDR_WIDTH-1 -: TAG_W]; local address = addr[BANK_ADDR_W-1:0].
- Write: with req high at a rising edge, mem[bank][local] <= data. No acknowledge; the write is always accepted unless it loses arbitration (below).
- Read latency: exactly 1 cycle. With req high at edge N, s_read_data_x shows mem[bank][local] after edge N.
- Read hold: s_read_data_x is loaded only on a granted read and keeps its value otherwise, including while req is low.
- Read-during-write, same address, same edge: the read returns the OLD contents; the new data is visible from the next read onward.
- Write arbitration (one write port per bank): if A and B write the same bank in the same cycle, A wins and B's write is dropped. Writes to different banks proceed in parallel.
- Read arbitration (one read port per bank): if A and B read the same bank in the same cycle, A is granted and s_read_data_b holds its previous value. Reads to different banks proceed in parallel.
- Read and write channels are independent, so one port may write bank X while the other (or the same) port reads bank X in the same cycle.
- Reset (asynchronous, active-high): s_read_data_a and s_read_data_b go to 0 immediately and stay 0 while reset is high.
- During reset, all requests are ignored and no writes occur.
- Memory contents are NOT reset; they keep their value across reset. Unwritten locations read as X in simulation.
- Reset asserted mid-operation: any write sampled at an edge while reset is high is dropped. After deassertion, previously written data remains readable.
- No address range checking is needed: every address within ADDR_WIDTH is valid, and bank/local indices wrap naturally within their widths.

Test Plan:
- Basic A path (defaults): write 0xDEADBEEF at A addr 0x005; read A addr 0x005 the next cycle -> s_read_data_a = 0xDEADBEEF one cycle after req; it holds with req low.
- Cross-port, different banks: A writes 0x11111111 at 0x3FF (bank 3). B then reads 0x3FF -> 0x11111111. Also B writes 0x22222222 at 0x010 (bank 0) while A reads 0x3FF in the same cycle -> A gets 0x11111111 and B's write lands.
- Parallel reads: A reads 0x005 (bank 0) and B reads 0x3FF (bank 3) in the same cycle -> both outputs are correct after one cycle.
- Conflicts: A and B write bank 1 (0x100 = 0xAAAA0000, 0x101 = 0xBBBB0000) in the same cycle -> 0x100 holds 0xAAAA0000 and 0x101 keeps its old value. A and B read bank 1 in the same cycle -> A returns data and s_read_data_b is unchanged.
- Read-during-write: 0x200 holds 0x1; in one cycle A writes 0x2 to 0x200 while B reads 0x200 -> B gets 0x1; a later read returns 0x2.
- Reset: with outputs nonzero, assert reset between clock edges -> both outputs are 0 immediately, before the next edge. Deassert and read back earlier data -> contents preserved.
